subleq_mem: RTL
===============

SUBLEQ_MEM -- requirements
Module: subleq_mem

Interface
REQ-001 SHALL have parameter BITS, default 8, giving word and address width; memory depth is 2**BITS words.
REQ-002 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port bus_write, input, 1, high when the CPU drives bus_data for a write.
REQ-005 SHALL have port bus_address, input, BITS, CPU word address.
REQ-006 SHALL have port bus_data, inout, BITS, bidirectional CPU data bus.
REQ-007 SHALL have port cpu_halt, input, 1, CPU halt indication.
REQ-008 SHALL have port cpu_reset, output, 1, synchronous reset to the CPU.
REQ-009 SHALL have ports host_valid in 1, host_we in 1, host_addr in BITS, host_wdata in BITS: host request.
REQ-010 SHALL have ports host_ready out 1, host_rvalid out 1, host_rdata out BITS: host response.
REQ-011 SHALL have port start, input, 1, host request to run the CPU.
REQ-012 SHALL have ports state out 2 (LOAD=0, RUN=1, HALTED=2) and write_count out 16 (CPU writes this run).

Function
REQ-013 SHALL implement FSM LOAD -> RUN on start; RUN -> HALTED on cpu_halt; HALTED -> RUN on start; no other transitions; code 3 unreachable.
REQ-014 SHALL drive cpu_reset=1 in LOAD and HALTED and cpu_reset=0 in RUN, decoded from registered state.
REQ-015 SHALL drive host_ready=1 in LOAD and HALTED and 0 in RUN.
REQ-016 SHALL, on a clock edge with host_valid&host_ready&host_we, write mem[host_addr]<=host_wdata.
REQ-017 SHALL, on a clock edge with host_valid&host_ready&!host_we, register host_rdata<=mem[host_addr] and pulse host_rvalid=1 for exactly the next cycle; host_rdata holds otherwise.
REQ-018 SHALL, when start and a host request coincide in LOAD/HALTED, complete the host request at that edge and enter RUN at the same edge.
REQ-019 SHALL, in RUN with bus_write=0, drive bus_data=mem[bus_address] combinationally (zero-cycle read, sampled by CPU at the next edge).
REQ-020 SHALL tri-state bus_data ({BITS{z}}) whenever state!=RUN or bus_write=1.
REQ-021 SHALL, in RUN with bus_write=1, write mem[bus_address]<=bus_data at the clock edge and increment write_count, saturating at 0xFFFF.
REQ-022 SHALL ignore bus_write and bus_address outside RUN (no memory write, no count).
REQ-023 SHALL clear write_count on the edge entering RUN.
REQ-024 SHALL ignore start while in RUN and ignore cpu_halt outside RUN.
REQ-025 SHALL give cpu_halt priority over nothing else in RUN: a bus write in the same cycle as cpu_halt still completes.
REQ-026 SHALL, on host write and read of the same address in consecutive cycles, return the newly written value (write-first across edges).

Reset
REQ-027 SHALL, on reset at any edge, including mid-RUN, set state=LOAD, cpu_reset=1, host_ready=1, host_rvalid=0, host_rdata=0, write_count=0.
REQ-028 SHALL NOT initialise or alter memory contents on reset; a bus write coincident with reset is discarded.
REQ-029 SHALL tri-state bus_data during and after reset until RUN.

Verification
REQ-030 Load: host writes {5,6,7} to addr 0..2, reads addr 1 -> host_rvalid one cycle later with host_rdata=6; bus_data stays Z.
REQ-031 Run read: after start, bench CPU model sets bus_address=2, bus_write=0 -> bus_data=7 same cycle; cpu_reset=0.
REQ-032 Run write: bus_write=1, bus_address=9, bus_data=0xF3 for one cycle -> mem[9]=0xF3, write_count=1, bus_data not driven by block.
REQ-033 Halt: cpu_halt=1 in RUN -> next cycle state=HALTED, cpu_reset=1, host_ready=1; host read addr 9 returns 0xF3; start -> RUN with write_count=0.
REQ-034 Saturation/ignores: 70000 bus writes in RUN -> write_count=0xFFFF; bus_write=1 during LOAD -> memory unchanged, count unchanged.
REQ-035 Reset mid-run: reset with bus_write=1 to addr 4 -> state=LOAD, mem[4] unchanged, addr 0..2 still {5,6,7}.

Source files
------------

// File: rtl/subleq_mem.sv
// Program/data memory for a SUBLEQ CPU: host load/inspect port while the CPU is
// held in reset, zero-latency CPU bus while running, and a per-run write counter.
module subleq_mem #(
  parameter int BITS = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            bus_write,
  input  logic [BITS-1:0] bus_address,
  inout  tri   [BITS-1:0] bus_data,
  input  logic            cpu_halt,
  output logic            cpu_reset,
  input  logic            host_valid,
  input  logic            host_we,
  input  logic [BITS-1:0] host_addr,
  input  logic [BITS-1:0] host_wdata,
  output logic            host_ready,
  output logic            host_rvalid,
  output logic [BITS-1:0] host_rdata,
  input  logic            start,
  output logic [1:0]      state,
  output logic [15:0]     write_count
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int DEPTH = 2 ** BITS;

  logic [BITS-1:0] mem_q [DEPTH];

  state_e          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic            rvalid_q, rvalid_d;
  logic [BITS-1:0] rdata_q, rdata_d;

  logic            mem_we;
  logic [BITS-1:0] mem_waddr;
  logic [BITS-1:0] mem_wdata;
  logic            host_fire;
  logic            bus_drive;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    host_fire = host_valid && (state_q != RUN);

    case (state_q)
      LOAD, HALTED: begin
        // A host request and start at the same edge both take effect.
        if (host_fire) begin
          if (host_we) begin
            mem_we    = 1'b1;
            mem_waddr = host_addr;
            mem_wdata = host_wdata;
          end else begin
            rdata_d  = mem_q[host_addr];
            rvalid_d = 1'b1;
          end
        end
        if (start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        if (bus_write) begin
          mem_we    = 1'b1;
          mem_waddr = bus_address;
          mem_wdata = bus_data;
          count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end
        if (cpu_halt) state_d = HALTED;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LOAD;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory has no reset; any write coincident with reset is dropped.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus_drive   = (state_q == RUN) && !bus_write;
  assign bus_data    = bus_drive ? mem_q[bus_address] : 'z;

  assign state       = state_q;
  assign cpu_reset   = (state_q != RUN);
  assign host_ready  = (state_q != RUN);
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign write_count = count_q;

endmodule
